sldu_addrgen_opq_arbiter: RTL and testbench
===========================================

# sldu_addrgen_opq_arbiter

Arbitrates the shared slide/address-generation operand queue of a lane between two requesters, the slide unit (SLDU) and the address generator (ADDRGEN). It forwards one command per accepted request to the operand queue. It tracks the in-flight commands in issue order and publishes the target of the head command, which the queue's consumer-ready filter uses. It also counts consumed operand beats and signals per-requester completion.

## Interface
- NrLanes, 4: lanes in the system; informational only, carried for consistency with the lane.
- CmdBufDepth, 4: command-buffer depth of the operand queue; also the depth of the internal tracker.
- LenWidth, 16: width of the beat-count fields.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- sldu_req_valid_i  in  1  SLDU command request.
- sldu_req_len_i  in  LenWidth  SLDU operand beats, 64-bit each.
- sldu_req_ready_o  out  1  SLDU request accepted.
- addrgen_req_valid_i  in  1  ADDRGEN command request.
- addrgen_req_len_i  in  LenWidth  ADDRGEN operand beats.
- addrgen_req_ready_o  out  1  ADDRGEN request accepted.
- cmd_valid_o  out  1  command to the operand queue.
- cmd_target_o  out  1  0 = ALU_SLDU, 1 = MFPU_ADDRGEN.
- cmd_len_o  out  LenWidth  beats of the command.
- cmd_ready_i  in  1  queue accepts the command.
- beat_fire_i  in  1  one operand beat consumed (queue valid & filtered ready).
- head_valid_o  out  1  tracker non-empty.
- head_target_o  out  1  target of the oldest in-flight command.
- sldu_done_o  out  1  pulse: last beat of an SLDU command consumed.
- addrgen_done_o  out  1  pulse: last beat of an ADDRGEN command consumed.
- spurious_beat_o  out  1  pulse: beat_fire_i arrived with the tracker empty.
- idle_o  out  1  tracker empty and no pending zero-length done.

## Operation
- Tracker: FIFO of {target, len}, CmdBufDepth entries, with read/write pointers that wrap modulo CmdBufDepth and an occupancy count of width $clog2(CmdBufDepth+1).
- Arbitration is round-robin between the two requesters:
  - A priority register, reset value SLDU, selects the winner when both requesters are valid.
  - After any accepted request, priority passes to the other requester.
  - A lone valid requester wins regardless of priority.
- Forwarding a request of nonzero length:
  - cmd_valid_o = winner valid & tracker not full.
  - cmd_target_o and cmd_len_o come from the winner.
  - Winner ready = cmd_valid_o & cmd_ready_i. On that handshake the entry is pushed.
- Zero-length request:
  - Accepted when it wins, with no cmd_valid_o and no push. The tracker-full state is ignored.
  - The matching done pulse is raised in the next cycle.
- Beat counter (LenWidth bits, reset 0):
  - Each beat_fire_i with the tracker non-empty increments the counter.
  - When counter == head.len-1 on a beat, the head is popped, the counter clears to 0, and the done pulse for head.target is registered.
- Spurious beat: beat_fire_i with the tracker empty is ignored and registers spurious_beat_o for one cycle.
- Simultaneous push and pop in the same cycle: occupancy is unchanged and both entries are handled correctly. A push into an empty tracker does not receive a beat in that same cycle, because head_valid_o is still 0.
- Full tracker: cmd_valid_o and both request readies for nonzero-length requests are 0.
- A zero-length done for one target and a last-beat done for the other can coincide. Both pulses assert.

## Timing
- Reset values: all registers clear, and all outputs are 0 except idle_o = 1. Priority points to SLDU.
- Reset mid-operation flushes the tracker, counter, pending done pulses and spurious flag. In-flight beats are lost; the environment resets the operand queue together with this block.
- Request/command paths are combinational (0-cycle): ready depends on valid, occupancy, priority and cmd_ready_i.
- head_valid_o and head_target_o are register outputs. They update the cycle after a push into an empty tracker or after a pop.
- Done and spurious pulses: exactly 1 cycle, registered, 1 cycle after the causing event.
- Throughput: one command per cycle, one beat per cycle.

## Test plan
- Reset, then SLDU len 3 and cmd_ready_i = 1 → cmd_target_o = 0, cmd_len_o = 3, accepted in cycle 0. head_valid_o = 1 from cycle 1. After 3 beat_fire_i, sldu_done_o pulses once and idle_o returns to 1.
- Both requesters valid continuously with len 1 → grants alternate SLDU, ADDRGEN, SLDU, ADDRGEN. head_target_o follows the issue order as beats retire.
- CmdBufDepth = 4, five ADDRGEN len 2 requests, no beats → 4 accepted. The 5th stalls with cmd_valid_o = 0. One retirement (2 beats) lets the 5th be accepted the cycle after the pop.
- Tracker holding one entry at its final beat, plus a new push in the same cycle → occupancy unchanged. The done pulse fires for the old target and head_target_o switches to the new entry.
- ADDRGEN len 0 with the tracker full → accepted with no command issued. addrgen_done_o pulses the next cycle.
- beat_fire_i with the tracker empty → spurious_beat_o pulses once and no state changes. Asserting rst_i with 2 entries in flight → outputs return to their reset values immediately.

Source files
------------

// File: rtl/sldu_addrgen_opq_arbiter.sv
// Round-robin arbiter between SLDU and ADDRGEN for the shared operand queue.
// It tracks in-flight commands in issue order and raises per-requester completion pulses.
module sldu_addrgen_opq_arbiter #(
  parameter int unsigned NrLanes     = 4,
  parameter int unsigned CmdBufDepth = 4,
  parameter int unsigned LenWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sldu_req_valid_i,
  input  logic [LenWidth-1:0] sldu_req_len_i,
  output logic                sldu_req_ready_o,
  input  logic                addrgen_req_valid_i,
  input  logic [LenWidth-1:0] addrgen_req_len_i,
  output logic                addrgen_req_ready_o,
  output logic                cmd_valid_o,
  output logic                cmd_target_o,
  output logic [LenWidth-1:0] cmd_len_o,
  input  logic                cmd_ready_i,
  input  logic                beat_fire_i,
  output logic                head_valid_o,
  output logic                head_target_o,
  output logic                sldu_done_o,
  output logic                addrgen_done_o,
  output logic                spurious_beat_o,
  output logic                idle_o
);

  localparam int unsigned PtrW = (CmdBufDepth > 1) ? $clog2(CmdBufDepth) : 1;
  localparam int unsigned CntW = $clog2(CmdBufDepth + 1);

  if (NrLanes < 1 || CmdBufDepth < 1 || LenWidth < 1) begin : g_param_check
    $error("sldu_addrgen_opq_arbiter: invalid parameters");
  end

  typedef struct packed {
    logic                target;
    logic [LenWidth-1:0] len;
  } entry_t;

  typedef enum logic {
    PRIO_SLDU    = 1'b0,
    PRIO_ADDRGEN = 1'b1
  } prio_e;

  entry_t              mem_q [CmdBufDepth];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [LenWidth-1:0] beat_cnt_q;
  prio_e               prio_q;
  logic                sldu_done_q, addrgen_done_q, spurious_q, zero_pend_q;

  entry_t head;
  entry_t win_entry;
  logic   win_addrgen, win_valid, win_zero;
  logic   empty, full, push, accept, beat_ok, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(CmdBufDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Arbitration and command forwarding; a lone requester wins regardless of priority
  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(CmdBufDepth));
  assign head        = mem_q[rd_ptr_q];
  assign win_valid   = sldu_req_valid_i | addrgen_req_valid_i;
  assign win_addrgen = addrgen_req_valid_i & (~sldu_req_valid_i | (prio_q == PRIO_ADDRGEN));
  assign win_entry   = '{target: win_addrgen,
                         len:    win_addrgen ? addrgen_req_len_i : sldu_req_len_i};
  assign win_zero    = (win_entry.len == '0);

  assign cmd_valid_o         = win_valid & ~win_zero & ~full;
  assign cmd_target_o        = win_entry.target;
  assign cmd_len_o           = win_entry.len;
  assign push                = cmd_valid_o & cmd_ready_i;
  // Zero-length requests bypass the queue, so a full tracker does not block them
  assign accept              = push | (win_valid & win_zero);
  assign sldu_req_ready_o    = accept & ~win_addrgen;
  assign addrgen_req_ready_o = accept & win_addrgen;

  assign beat_ok = beat_fire_i & ~empty;
  assign pop     = beat_ok & (beat_cnt_q == head.len - LenWidth'(1));

  assign head_valid_o    = ~empty;
  assign head_target_o   = ~empty & head.target;
  assign sldu_done_o     = sldu_done_q;
  assign addrgen_done_o  = addrgen_done_q;
  assign spurious_beat_o = spurious_q;
  assign idle_o          = empty & ~zero_pend_q;

  // Tracker storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(CmdBufDepth); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= win_entry;
    end
  end

  // Pointers, occupancy, beat counter and priority
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      prio_q     <= PRIO_SLDU;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (pop)          beat_cnt_q <= '0;
      else if (beat_ok) beat_cnt_q <= beat_cnt_q + LenWidth'(1);
      if (accept) prio_q <= win_addrgen ? PRIO_SLDU : PRIO_ADDRGEN;
    end
  end

  // One-cycle completion and spurious-beat pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sldu_done_q    <= 1'b0;
      addrgen_done_q <= 1'b0;
      spurious_q     <= 1'b0;
      zero_pend_q    <= 1'b0;
    end else begin
      sldu_done_q    <= (accept & win_zero & ~win_addrgen) | (pop & ~head.target);
      addrgen_done_q <= (accept & win_zero & win_addrgen) | (pop & head.target);
      spurious_q     <= beat_fire_i & empty;
      zero_pend_q    <= accept & win_zero;
    end
  end

endmodule

// File: tb/tb_sldu_addrgen_opq_arbiter.sv
// Directed plus randomized bench for sldu_addrgen_opq_arbiter, checked against a
// queue-based reference model of in-flight commands.
module tb_sldu_addrgen_opq_arbiter;

  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          sldu_req_valid_i, addrgen_req_valid_i;
  logic [LW-1:0] sldu_req_len_i, addrgen_req_len_i;
  logic          sldu_req_ready_o, addrgen_req_ready_o;
  logic          cmd_valid_o, cmd_target_o, cmd_ready_i, beat_fire_i;
  logic [LW-1:0] cmd_len_o;
  logic          head_valid_o, head_target_o;
  logic          sldu_done_o, addrgen_done_o, spurious_beat_o, idle_o;

  always #5 clk_i = ~clk_i;

  sldu_addrgen_opq_arbiter #(.NrLanes(4), .CmdBufDepth(DEPTH), .LenWidth(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sldu_req_valid_i(sldu_req_valid_i), .sldu_req_len_i(sldu_req_len_i),
    .sldu_req_ready_o(sldu_req_ready_o),
    .addrgen_req_valid_i(addrgen_req_valid_i), .addrgen_req_len_i(addrgen_req_len_i),
    .addrgen_req_ready_o(addrgen_req_ready_o),
    .cmd_valid_o(cmd_valid_o), .cmd_target_o(cmd_target_o), .cmd_len_o(cmd_len_o),
    .cmd_ready_i(cmd_ready_i), .beat_fire_i(beat_fire_i),
    .head_valid_o(head_valid_o), .head_target_o(head_target_o),
    .sldu_done_o(sldu_done_o), .addrgen_done_o(addrgen_done_o),
    .spurious_beat_o(spurious_beat_o), .idle_o(idle_o)
  );

  // Reference model: in-flight commands as a queue, target 0 = SLDU, 1 = ADDRGEN
  typedef struct {
    bit tgt;
    int len;
  } ent_t;

  ent_t q[$];
  int   beats;
  bit   prio_addrgen;
  bit   e_sdone, e_adone, e_spur, e_zpend;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    beats = 0;
    prio_addrgen = 0;
    e_sdone = 0; e_adone = 0; e_spur = 0; e_zpend = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
    chk("rst_sldu_ready", 32'(sldu_req_ready_o), 0);
    chk("rst_addrgen_ready", 32'(addrgen_req_ready_o), 0);
    chk("rst_head_valid", 32'(head_valid_o), 0);
    chk("rst_head_target", 32'(head_target_o), 0);
    chk("rst_sldu_done", 32'(sldu_done_o), 0);
    chk("rst_addrgen_done", 32'(addrgen_done_o), 0);
    chk("rst_spurious", 32'(spurious_beat_o), 0);
    chk("rst_idle", 32'(idle_o), 1);
  endtask

  task automatic do_reset();
    sldu_req_valid_i = 0; sldu_req_len_i = '0;
    addrgen_req_valid_i = 0; addrgen_req_len_i = '0;
    cmd_ready_i = 0; beat_fire_i = 0;
    rst_i = 1;
    #1;
    model_clear();
    check_reset_outputs();
    @(negedge clk_i);
    rst_i = 0;
    @(posedge clk_i);
    #1;
  endtask

  // One clock cycle: drive, check against the model at the falling edge, advance the model
  task automatic cyc(input bit sv, input int sl, input bit av, input int al,
                     input bit cr, input bit bf);
    bit has_win, win_a, zero, full, cvalid, s_rdy, a_rdy;
    int wlen;
    sldu_req_valid_i    = sv;
    sldu_req_len_i      = LW'(sl);
    addrgen_req_valid_i = av;
    addrgen_req_len_i   = LW'(al);
    cmd_ready_i         = cr;
    beat_fire_i         = bf;
    @(negedge clk_i);
    full    = (q.size() == DEPTH);
    has_win = sv || av;
    win_a   = av && (!sv || prio_addrgen);
    wlen    = win_a ? al : sl;
    zero    = (wlen == 0);
    cvalid  = has_win && !zero && !full;
    s_rdy   = has_win && !win_a && (zero || (cvalid && cr));
    a_rdy   = has_win && win_a && (zero || (cvalid && cr));
    chk("cmd_valid", 32'(cmd_valid_o), 32'(cvalid));
    if (cvalid) begin
      chk("cmd_target", 32'(cmd_target_o), 32'(win_a));
      chk("cmd_len", 32'(cmd_len_o), 32'(wlen));
    end
    chk("sldu_ready", 32'(sldu_req_ready_o), 32'(s_rdy));
    chk("addrgen_ready", 32'(addrgen_req_ready_o), 32'(a_rdy));
    chk("head_valid", 32'(head_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) chk("head_target", 32'(head_target_o), 32'(q[0].tgt));
    chk("sldu_done", 32'(sldu_done_o), 32'(e_sdone));
    chk("addrgen_done", 32'(addrgen_done_o), 32'(e_adone));
    chk("spurious", 32'(spurious_beat_o), 32'(e_spur));
    chk("idle", 32'(idle_o), 32'(q.size() == 0 && !e_zpend));
    e_sdone = 0; e_adone = 0; e_spur = 0; e_zpend = 0;
    if (bf) begin
      if (q.size() == 0) e_spur = 1;
      else begin
        beats++;
        if (beats == q[0].len) begin
          if (q[0].tgt) e_adone = 1; else e_sdone = 1;
          void'(q.pop_front());
          beats = 0;
        end
      end
    end
    if (s_rdy || a_rdy) begin
      prio_addrgen = !win_a;
      if (zero) begin
        e_zpend = 1;
        if (win_a) e_adone = 1; else e_sdone = 1;
      end else q.push_back('{tgt: win_a, len: wlen});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (q.size() != 0 || e_sdone || e_adone); i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_empty", 32'(head_valid_o), 0);
  endtask

  initial begin
    do_reset();

    // Single SLDU command of 3 beats
    cyc(1, 3, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Both requesting len 1: grants alternate
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 1, 1, 1);
    drain();

    // Fill the tracker with ADDRGEN len 2, stall the fifth, then retire one
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 2, 1, 0);
    cyc(0, 0, 1, 2, 1, 1);
    cyc(0, 0, 1, 2, 1, 1);
    cyc(0, 0, 1, 2, 1, 0);
    drain();

    // Final beat of one entry coincides with a push
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 2, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Zero-length ADDRGEN with the tracker full
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    drain();

    // Spurious beats
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 1, 1);
    drain();

    // Reset with two entries in flight
    cyc(1, 2, 0, 0, 1, 0);
    cyc(0, 0, 1, 3, 1, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)),
          ($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3));
      if (i == 300) do_reset();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
